// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmitter arbiter: byte width,
// FSM state encoding and a ring-index helper.
package uart_tx_arbiter_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOCKED    = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } arb_state_e;

  function automatic int unsigned ring_next(input int unsigned idx, input int unsigned n);
    if (idx + 32'd1 >= n) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of valid_i at or after
// start_i, wrapping around.
module uart_tx_arbiter_rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] valid_i,
  input  logic [W-1:0] start_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  logic [W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest valid index wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int off = int'(N) - 1; off >= 0; off--) begin
      cand    = W'((int'(start_i) + off) % int'(N));
      idx_o   = valid_i[cand] ? cand : idx_o;
      found_o = found_o | valid_i[cand];
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one byte-wide UART transmitter
// between NREQ requesters, pacing strobes on the transmitter busy flag.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDXW    = 2,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TOW     = 10
) (
  input  logic                   sys_clk_i,
  input  logic                   sys_rst_n_i,
  input  logic [NREQ-1:0]        req_valid_i,
  input  logic [BYTE_W*NREQ-1:0] req_data_i,
  input  logic [NREQ-1:0]        req_last_i,
  output logic [NREQ-1:0]        req_ready_o,
  output logic                   uart_wr_o,
  output logic [BYTE_W-1:0]      uart_dat_o,
  input  logic                   uart_busy_i,
  output logic [IDXW-1:0]        grant_o,
  output logic                   active_o
);

  localparam logic [TOW-1:0] TOUT_LAST = TOW'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  logic [IDXW-1:0]   grant_q, grant_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic [BYTE_W-1:0] dat_q, dat_d;
  logic              last_q, last_d;
  logic [TOW-1:0]    tout_q, tout_d;

  logic [IDXW-1:0]   pick_idx_s;
  logic              pick_found_s;
  logic [IDXW-1:0]   release_ptr_s;
  logic              owner_valid_s;
  logic              owner_last_s;
  logic [BYTE_W-1:0] owner_data_s;
  logic              sel_s;

  uart_tx_arbiter_rr_pick #(
    .N (NREQ),
    .W (IDXW)
  ) u_pick (
    .valid_i (req_valid_i),
    .start_i (ptr_q),
    .idx_o   (pick_idx_s),
    .found_o (pick_found_s)
  );

  assign release_ptr_s = IDXW'(ring_next(32'(grant_q), NREQ));

  // Select the current owner's request lines.
  always_comb begin
    owner_valid_s = 1'b0;
    owner_last_s  = 1'b0;
    owner_data_s  = '0;
    sel_s         = 1'b0;
    for (int k = 0; k < int'(NREQ); k++) begin
      sel_s         = (grant_q == IDXW'(k));
      owner_valid_s = owner_valid_s | (sel_s & req_valid_i[k]);
      owner_last_s  = owner_last_s | (sel_s & req_last_i[k]);
      owner_data_s  = owner_data_s | ({BYTE_W{sel_s}} & req_data_i[k*BYTE_W +: BYTE_W]);
    end
  end

  // State and datapath registers.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      dat_q   <= '0;
      last_q  <= 1'b0;
      tout_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      dat_q   <= dat_d;
      last_q  <= last_d;
      tout_q  <= tout_d;
    end
  end

  // Next-state logic; the pointer only advances when a grant is released.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    dat_d   = dat_q;
    last_d  = last_q;
    tout_d  = tout_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          grant_d = pick_idx_s;
          tout_d  = '0;
          state_d = ST_LOCKED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (owner_valid_s) begin
          dat_d   = owner_data_s;
          last_d  = owner_last_s;
          tout_d  = '0;
          state_d = ST_ISSUE;
        end else if (tout_q == TOUT_LAST) begin
          tout_d  = '0;
          ptr_d   = release_ptr_s;
          state_d = ST_IDLE;
        end else begin
          tout_d  = tout_q + TOW'(1);
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (uart_busy_i) begin
          state_d = ST_WAIT_IDLE;
        end else begin
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_IDLE: begin
        if (!uart_busy_i) begin
          tout_d = '0;
          if (last_q) begin
            ptr_d   = release_ptr_s;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_LOCKED;
          end
        end else begin
          state_d = ST_WAIT_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from the current state; ready is a pass-through of the owner's valid.
  always_comb begin
    req_ready_o = '0;
    uart_wr_o   = 1'b0;
    case (state_q)
      ST_LOCKED: begin
        req_ready_o[grant_q] = owner_valid_s;
      end
      ST_ISSUE: begin
        uart_wr_o = 1'b1;
      end
      default: begin
        req_ready_o = '0;
        uart_wr_o   = 1'b0;
      end
    endcase
  end

  assign uart_dat_o = dat_q;
  assign grant_o    = grant_q;
  assign active_o   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural transmitter
// (busy high for 10 cycles starting the cycle after each strobe).
module tb_uart_tx_arbiter;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] dat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = 4'd0;
  logic [3:0]  req_last = 4'd0;
  logic [31:0] req_data = 32'd0;
  logic [3:0]  req_ready;
  logic        uart_wr;
  logic [7:0]  uart_dat;
  logic        uart_busy;
  logic [1:0]  grant;
  logic        active;

  int busy_cnt;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int ready0_cnt = 0;
  bit rand_mode = 1'b0;

  exp_t       sb[$];
  logic [8:0] txq[4][$];
  logic [7:0] rexp[4][$];
  int         strobe_t[$];

  uart_tx_arbiter #(
    .NREQ(4), .IDXW(2), .TIMEOUT(16), .TOW(5)
  ) dut (
    .sys_clk_i   (clk),
    .sys_rst_n_i (rst_n),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .uart_wr_o   (uart_wr),
    .uart_dat_o  (uart_dat),
    .uart_busy_i (uart_busy),
    .grant_o     (grant),
    .active_o    (active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_cnt <= 0;
    else if (uart_wr) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign uart_busy = (busy_cnt != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Requester driver: presents queue heads, pops on a sampled handshake.
  initial begin : driver
    logic [3:0] fire;
    logic [8:0] head;
    @(negedge clk);
    forever begin
      #4;
      fire = req_valid & req_ready;
      @(negedge clk);
      if (fire[0]) ready0_cnt++;
      for (int k = 0; k < 4; k++) begin
        if (fire[k] && txq[k].size() > 0) void'(txq[k].pop_front());
        if (txq[k].size() > 0) begin
          head = txq[k][0];
          req_valid[k] = 1'b1;
          req_last[k] = head[8];
          req_data[8*k +: 8] = head[7:0];
        end else begin
          req_valid[k] = 1'b0;
          req_last[k] = 1'b0;
        end
      end
    end
  end

  // Monitor: protocol checks every cycle, scoreboard pop on every strobe.
  always @(negedge clk) begin
    exp_t e;
    logic [1:0] k;
    if (rst_n) begin
      check("wr_while_busy", 32'(uart_wr & uart_busy), 32'd0);
      check("nonowner_ready", 32'(req_ready & ~(4'b0001 << grant)), 32'd0);
      if (uart_wr) begin
        strobe_t.push_back(cyc);
        if (rand_mode) begin
          k = uart_dat[7:6];
          check("rand_grant", 32'(grant), 32'(k));
          check("rand_pending", 32'(rexp[k].size() != 0), 32'd1);
          if (rexp[k].size() != 0) check("rand_data", 32'(uart_dat), 32'(rexp[k].pop_front()));
        end else begin
          check("sb_pending", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("strobe_grant", 32'(grant), 32'(e.idx));
            check("strobe_data", 32'(uart_dat), 32'(e.dat));
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rand_mode = 1'b0;
    for (int k = 0; k < 4; k++) begin
      txq[k].delete();
      rexp[k].delete();
    end
    sb.delete();
    strobe_t.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  function automatic bit all_drained();
    bit d;
    d = (sb.size() == 0) && !active && !uart_busy;
    for (int k = 0; k < 4; k++) d = d && (txq[k].size() == 0) && (rexp[k].size() == 0);
    return d;
  endfunction

  task automatic wait_idle(input string name, input int budget, output int done_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (all_drained()) begin
        ok = 1'b1;
        break;
      end
    end
    done_cyc = cyc;
    check({name, "_drain"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_strobes(input string name, input int n, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (strobe_t.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_strobe_seen"}, 32'(ok), 32'd1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    int dc;
    int seq[4];
    bit ok;
    logic [1:0] kk;
    logic [7:0] d;
    logic lst;

    // Reset state
    do_reset();
    check("rst_active", 32'(active), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_dat", 32'(uart_dat), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_wr", 32'(uart_wr), 32'd0);

    // Single byte
    do_reset();
    ready0_cnt = 0;
    sb.push_back({2'd0, 8'hA5});
    txq[0].push_back({1'b1, 8'hA5});
    wait_idle("single", 300, dc);
    check("single_strobes", 32'(strobe_t.size()), 32'd1);
    check("single_ready0", 32'(ready0_cnt), 32'd1);
    if (strobe_t.size() > 0) check("single_release_cycle", 32'(dc - strobe_t[0]), 32'd12);

    // Message lock against a waiting requester
    do_reset();
    sb.push_back({2'd1, 8'h48});
    sb.push_back({2'd1, 8'h69});
    sb.push_back({2'd1, 8'h0A});
    sb.push_back({2'd2, 8'hB2});
    txq[1].push_back({1'b0, 8'h48});
    txq[1].push_back({1'b0, 8'h69});
    txq[1].push_back({1'b1, 8'h0A});
    txq[2].push_back({1'b1, 8'hB2});
    wait_idle("lock", 400, dc);
    check("lock_strobes", 32'(strobe_t.size()), 32'd4);
    if (strobe_t.size() >= 4) begin
      check("lock_gap1", 32'(strobe_t[1] - strobe_t[0]), 32'd13);
      check("lock_gap2", 32'(strobe_t[2] - strobe_t[1]), 32'd13);
      check("lock_handover_gap", 32'(strobe_t[3] - strobe_t[2]), 32'd14);
    end

    // Round-robin fairness from reset
    do_reset();
    sb.push_back({2'd0, 8'h10});
    sb.push_back({2'd1, 8'h21});
    sb.push_back({2'd2, 8'h32});
    sb.push_back({2'd3, 8'h43});
    sb.push_back({2'd0, 8'h04});
    txq[0].push_back({1'b1, 8'h10});
    txq[0].push_back({1'b1, 8'h04});
    txq[1].push_back({1'b1, 8'h21});
    txq[2].push_back({1'b1, 8'h32});
    txq[3].push_back({1'b1, 8'h43});
    wait_idle("rr", 500, dc);
    check("rr_strobes", 32'(strobe_t.size()), 32'd5);

    // Timeout after a non-last byte
    do_reset();
    sb.push_back({2'd3, 8'h3C});
    txq[3].push_back({1'b0, 8'h3C});
    wait_strobes("to", 1, 200);
    sb.push_back({2'd0, 8'h5A});
    txq[0].push_back({1'b1, 8'h5A});
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!active) begin
        ok = 1'b1;
        break;
      end
    end
    check("to_release_seen", 32'(ok), 32'd1);
    if (strobe_t.size() > 0) check("to_release_cycle", 32'(cyc - strobe_t[0]), 32'd28);
    wait_idle("to", 300, dc);
    check("to_strobes", 32'(strobe_t.size()), 32'd2);
    if (strobe_t.size() >= 2) check("to_next_gap", 32'(strobe_t[1] - strobe_t[0]), 32'd30);

    // Reset while waiting for the transmitter
    do_reset();
    sb.push_back({2'd2, 8'h77});
    txq[2].push_back({1'b1, 8'h77});
    wait_strobes("mrst", 1, 200);
    repeat (4) @(negedge clk);
    check("mrst_pre_grant", 32'(grant), 32'd2);
    check("mrst_pre_busy", 32'(uart_busy), 32'd1);
    check("mrst_pre_dat", 32'(uart_dat), 32'h77);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_active", 32'(active), 32'd0);
    check("mrst_grant", 32'(grant), 32'd0);
    check("mrst_dat", 32'(uart_dat), 32'd0);
    check("mrst_wr", 32'(uart_wr), 32'd0);
    check("mrst_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.push_back({2'd0, 8'h55});
    txq[0].push_back({1'b1, 8'h55});
    wait_idle("mrst", 300, dc);
    check("mrst_strobes", 32'(strobe_t.size()), 32'd2);

    // Random multi-requester run
    do_reset();
    rand_mode = 1'b1;
    for (int k = 0; k < 4; k++) seq[k] = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (txq[k].size() < 3 && $urandom_range(0, 3) == 0) begin
          kk = 2'(k);
          d = {kk, 6'(seq[k])};
          lst = ($urandom_range(0, 2) == 0);
          txq[k].push_back({lst, d});
          rexp[k].push_back(d);
          seq[k]++;
        end
      end
    end
    wait_idle("rand", 2000, dc);
    for (int k = 0; k < 4; k++) check("rand_left", 32'(rexp[k].size()), 32'd0);
    check("rand_enough_strobes", 32'(strobe_t.size() >= 50), 32'd1);
    rand_mode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
